// File: rtl/conv1_layer1_pkg.sv
// Shared constants and types for the conv1 layer1 dense mult array controller.
package conv1_layer1_pkg;
  localparam int LANES   = 25;
  localparam int DW      = 16;
  localparam int VEC_W   = LANES * DW;
  localparam int ARR_LAT = 4;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;
endpackage

// File: rtl/mxmult_res_fifo.sv
// Result FIFO between the mult array and the consumer; pushes while full are dropped.
module mxmult_res_fifo
  import conv1_layer1_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  vec_t                   wdata,
  input  logic                   pop,
  output vec_t                   rdata,
  output logic [$clog2(DEPTH):0] cnt,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  vec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (cnt == DEPTH[AW:0]);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/conv1_layer1_mxmult_ctrl.sv
// Job sequencer for the conv1 layer1 mult array with credit-based result buffering.
// Optional counters stall_cnt/job_cyc are built when MXMULT_CTRL_PERF_EN is defined.
module conv1_layer1_mxmult_ctrl
  import conv1_layer1_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] job_len,
  output logic             busy,
  output logic             done,
  input  vec_t             src_fea,
  input  vec_t             src_a,
  input  logic             src_v,
  output logic             src_rdy,
  output logic             arr_data_v,
  output logic             arr_halt,
  output vec_t             arr_in_fea,
  output vec_t             arr_a_mx,
  input  vec_t             arr_res,
  input  logic             arr_res_v,
  output vec_t             res_out,
  output logic             res_v,
  input  logic             res_rdy,
  output logic             err
`ifdef MXMULT_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      job_cyc
`endif
);
  localparam int IW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW:0] CREDITS = FIFO_DEPTH[IW:0];

  state_e           state;
  logic [LEN_W-1:0] remain;
  logic [IW-1:0]    inflight;
  logic [IW-1:0]    fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             issue, pop, res_ok;
  vec_t             fea_q, a_q;

  assign src_rdy  = (state == S_RUN) && (remain != '0) &&
                    (({1'b0, inflight} + {1'b0, fifo_cnt}) < CREDITS);
  assign issue    = src_v && src_rdy;
  assign res_v    = !fifo_empty;
  assign pop      = res_v && res_rdy;
  assign res_ok   = arr_res_v && (inflight != '0);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign arr_halt = (state == S_IDLE) && (inflight == '0);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= S_IDLE;
      remain <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (start) begin
            remain <= job_len;
            state  <= (job_len == '0) ? S_DONE : S_RUN;
          end
        S_RUN:
          if (issue) begin
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) state <= S_DRAIN;
          end
        // Leave as the last entry is popped so done lands the cycle after it.
        S_DRAIN:
          if (inflight == '0 && (fifo_empty || (fifo_cnt == IW'(1) && res_rdy)))
            state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) inflight <= '0;
    else if (issue && !res_ok) inflight <= inflight + 1'b1;
    else if (!issue && res_ok) inflight <= inflight - 1'b1;

  // The array enables its DSPs one cycle after data_v, so operands lag by one stage.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      arr_data_v <= 1'b0;
      fea_q      <= '0;
      a_q        <= '0;
      arr_in_fea <= '0;
      arr_a_mx   <= '0;
    end else begin
      arr_data_v <= issue;
      if (issue) begin
        fea_q <= src_fea;
        a_q   <= src_a;
      end
      if (arr_data_v) begin
        arr_in_fea <= fea_q;
        arr_a_mx   <= a_q;
      end
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (arr_res_v && (inflight == '0 || fifo_full)) err <= 1'b1;

  mxmult_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (arr_res_v),
    .wdata (arr_res),
    .pop   (pop),
    .rdata (res_out),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MXMULT_CTRL_PERF_EN
  logic start_acc;
  assign start_acc = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt <= '0;
      job_cyc   <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
      job_cyc   <= 32'd1;
    end else begin
      if (state == S_RUN && src_v && !src_rdy && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (state != S_IDLE && job_cyc != '1)
        job_cyc <= job_cyc + 1'b1;
    end
`endif
endmodule
